// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external WIDTHxWIDTH multiplier among NREQ requesters.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b per-requester request channel
// (operands packed WIDTH bits per requester); resp_valid/resp_ready/resp_id/resp_prod response channel;
// mul_a/mul_b/mul_prod connect to the shared combinational multiplier; err is the sticky self-check flag.
// Define MULT_SELFCHECK_EN to compare mul_prod against mul_a*mul_b at capture; otherwise err is tied to 0.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 4,
  parameter int IDW = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [2*WIDTH-1:0]      resp_prod,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_prod,
  output logic                    err
);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);
  logic [1:0] state;
  logic [IDW-1:0] rr_ptr, g, idx;
  logic found;
  logic [CW-1:0] cnt;
  logic capture;
  // walk from rr_ptr upward with wrap; the first active requester wins
  always_comb begin
    g = '0;
    found = 1'b0;
    idx = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[idx]) begin
        g = idx;
        found = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end
  assign req_ready = (state == IDLE && found) ? (NREQ'(1) << g) : '0;
  assign capture = (state == WAIT) && (cnt == CW'(1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_prod <= '0;
      mul_a <= '0;
      mul_b <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        mul_a <= req_a[g*WIDTH +: WIDTH];
        mul_b <= req_b[g*WIDTH +: WIDTH];
        resp_id <= g;
        rr_ptr <= (g == LAST) ? '0 : g + 1'b1;
        cnt <= CW'(MUL_LAT);
        state <= WAIT;
      end
    end else if (state == WAIT) begin
      if (capture) begin
        resp_prod <= mul_prod;
        resp_valid <= 1'b1;
        state <= RESP;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
      state <= IDLE;
    end
  end
`ifdef MULT_SELFCHECK_EN
  logic [2*WIDTH-1:0] ref_prod;
  assign ref_prod = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (capture && mul_prod != ref_prod) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed bench with a transaction-level reference model checked every cycle.
module tb_mult_share_arbiter;
  localparam int NREQ = 4, W = 4, IDW = 2, LAT = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [W-1:0] ta [NREQ];
  logic [W-1:0] tbv [NREQ];
  logic [NREQ*W-1:0] req_a, req_b;
  logic resp_valid, resp_ready = 1'b1;
  logic [IDW-1:0] resp_id;
  logic [2*W-1:0] resp_prod, mul_prod;
  logic [W-1:0] mul_a, mul_b;
  logic err;
  logic corrupt = 1'b0;
  int errors = 0, checks = 0;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_prod(resp_prod), .mul_a(mul_a), .mul_b(mul_b),
    .mul_prod(mul_prod), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tbv[i];
    end
  end

  // stand-in for the shared multiplier; corrupt flips the LSB to exercise the self-check
  assign mul_prod = (8'(mul_a) * 8'(mul_b)) ^ {7'b0, corrupt};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model: one operation in flight, response due LAT edges after the grant
  int m_rr, m_g, cyc, m_cap;
  logic m_busy, m_rv, m_err, m_bad;
  logic [IDW-1:0] m_id;
  logic [2*W-1:0] m_pend, m_prod;
  logic [W-1:0] m_ma, m_mb;
  logic [NREQ-1:0] m_ready;

  always_comb begin
    m_g = -1;
    for (int k = 0; k < NREQ; k++)
      if (m_g < 0 && req_valid[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
  end
  assign m_ready = (!m_busy && m_g >= 0) ? 4'(1 << m_g) : 4'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr <= 0; m_busy <= 0; m_rv <= 0; m_err <= 0; m_bad <= 0; m_id <= 0;
      m_pend <= 0; m_prod <= 0; m_ma <= 0; m_mb <= 0; cyc <= 0; m_cap <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy) begin
        if (m_g >= 0) begin
          m_busy <= 1; m_id <= IDW'(m_g); m_ma <= ta[m_g]; m_mb <= tbv[m_g];
          m_pend <= (8'(ta[m_g]) * 8'(tbv[m_g])) ^ {7'b0, corrupt};
          m_bad <= corrupt; m_cap <= cyc + LAT; m_rr <= (m_g + 1) % NREQ;
        end
      end else if (!m_rv) begin
        if (cyc == m_cap) begin
          m_rv <= 1; m_prod <= m_pend;
`ifdef MULT_SELFCHECK_EN
          if (m_bad) m_err <= 1;
`endif
        end
      end else if (resp_ready) begin
        m_rv <= 0; m_busy <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_ready);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_id", resp_id, m_id);
    chk("resp_prod", resp_prod, m_prod);
    chk("mul_a", mul_a, m_ma);
    chk("mul_b", mul_b, m_mb);
    chk("err", err, m_err);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i, input bit rnd);
    #1;
    for (int n = 0; n < 30 && !req_ready[i]; n++) begin
      if (rnd) resp_ready = ($urandom_range(0, 3) != 0);
      tick;
      #1;
    end
    chk("grant_seen", req_ready[i], 1);
  endtask

  task automatic wait_resp(input bit rnd);
    for (int n = 0; n < 30 && !resp_valid; n++) begin
      if (rnd) resp_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    chk("resp_seen", resp_valid, 1);
  endtask

  int order[$];
  int exp_ord[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tbv[i] = '0; end
    tick; tick;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_prod", resp_prod, 0);
    chk("rst_err", err, 0);
    rst = 0;
    // reset in the middle of an operation
    ta[0] = 5; tbv[0] = 6; req_valid = 4'b0001;
    #1 chk("mid_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    chk("mid_mul_a", mul_a, 5);
    chk("mid_mul_b", mul_b, 6);
    rst = 1;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    chk("mid_rst_id", resp_id, 0);
    tick;
    rst = 0;
    repeat (3) tick;
    chk("mid_no_resp", resp_valid, 0);
    ta[1] = 2; tbv[1] = 3; req_valid = 4'b0011;
    #1 chk("mid_rr0", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    wait_resp(0);
    chk("mid_prod", resp_prod, 30);
    tick;
    // single request, one-cycle settle
    ta[2] = 13; tbv[2] = 11; req_valid = 4'b0100;
    #1 chk("one_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    tick;
    chk("one_valid", resp_valid, 1);
    chk("one_id", resp_id, 2);
    chk("one_prod", resp_prod, 143);
    tick;
    chk("one_drop", resp_valid, 0);
    rst = 1; tick; rst = 0;
    // round robin with everyone requesting
    ta[0] = 1; tbv[0] = 2; ta[1] = 3; tbv[1] = 4; ta[2] = 7; tbv[2] = 5; ta[3] = 15; tbv[3] = 15;
    req_valid = 4'hF;
    for (int n = 0; n < 100 && order.size() < 6; n++) begin
      #1;
      if (req_ready != 0) order.push_back($clog2(req_ready));
      if (resp_valid && resp_id == 3) chk("rr_p3", resp_prod, 225);
      tick;
    end
    req_valid = '0;
    chk("rr_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("rr_order", order[i], exp_ord[i]);
    wait_resp(0);
    tick;
    // backpressure
    ta[1] = 9; tbv[1] = 3; req_valid = 4'b0010; resp_ready = 0;
    wait_resp(0);
    chk("bp_id", resp_id, 1);
    chk("bp_prod", resp_prod, 27);
    repeat (5) begin
      tick;
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_prod", resp_prod, 27);
      chk("bp_hold_id", resp_id, 1);
      chk("bp_hold_ready", req_ready, 0);
    end
    resp_ready = 1;
    tick;
    #1;
    chk("bp_done", resp_valid, 0);
    chk("bp_regrant", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    wait_resp(0);
    tick;
    // full operand sweep on requester 1 with random response stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ta[1] = 4'(a); tbv[1] = 4'(b); req_valid = 4'b0010;
        wait_grant(1, 1);
        tick;
        req_valid = '0;
        wait_resp(1);
        chk("sweep_prod", resp_prod, a * b);
      end
    end
    resp_ready = 1;
    repeat (3) tick;
`ifdef MULT_SELFCHECK_EN
    corrupt = 1; ta[0] = 7; tbv[0] = 9; req_valid = 4'b0001;
    wait_grant(0, 0);
    tick;
    req_valid = '0;
    wait_resp(0);
    chk("sc_prod", resp_prod, 62);
    chk("sc_err", err, 1);
    tick;
    corrupt = 0; ta[0] = 2; tbv[0] = 3; req_valid = 4'b0001;
    wait_grant(0, 0);
    tick;
    req_valid = '0;
    wait_resp(0);
    chk("sc_good_prod", resp_prod, 6);
    chk("sc_sticky", err, 1);
    tick;
    rst = 1; #1;
    chk("sc_clear", err, 0);
    tick; rst = 0;
`else
    chk("err_off", err, 0);
`endif
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
